// File: rtl/rst_call_push_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// rst_call_push_sequencer_pkg
// Shared definitions for the RST/CALL push sequencer:
//   state_e            - sequencer FSM states
//   RST_VECTOR_SHIFT   - RST index to vector address shift (index * 8)
//   PUSH_HIGH_FIRST    - push byte order: PC high byte first, at SP-1
//   PUSH_*_OFFSET      - SP decrement applied for the first/second pushed byte
// -----------------------------------------------------------------------------
package rst_call_push_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_HI,
        ST_WR_LO,
        ST_LOAD,
        ST_DONE
    } state_e;

    localparam int unsigned RST_VECTOR_SHIFT   = 3;
    localparam bit          PUSH_HIGH_FIRST    = 1'b1;
    localparam int unsigned PUSH_FIRST_OFFSET  = 1;
    localparam int unsigned PUSH_SECOND_OFFSET = 2;

endpackage

// File: rtl/rst_call_push_sequencer_if.sv
// -----------------------------------------------------------------------------
// rst_call_push_sequencer_if
// Bundles the decoder request, memory write port and register-file update
// signals of the push sequencer.
//   master : decoder / memory / register-file side (drives requests, mem_ready)
//   slave  : the sequencer (drives memory writes, SP/PC loads, busy, done)
// -----------------------------------------------------------------------------
interface rst_call_push_sequencer_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    // request from opcode decode
    logic              start;
    logic              is_call;
    logic [2:0]        vector;
    logic [ADDR_W-1:0] call_target;
    logic [ADDR_W-1:0] pc_in;
    logic [ADDR_W-1:0] sp_in;
    // memory write port
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_ready;
    // register file updates and status
    logic [ADDR_W-1:0] sp_out;
    logic              sp_load;
    logic [ADDR_W-1:0] pc_out;
    logic              pc_load;
    logic              busy;
    logic              done;

    modport master (
        output start, is_call, vector, call_target, pc_in, sp_in, mem_ready,
        input  mem_addr, mem_wdata, mem_we, sp_out, sp_load, pc_out, pc_load,
               busy, done
    );

    modport slave (
        input  start, is_call, vector, call_target, pc_in, sp_in, mem_ready,
        output mem_addr, mem_wdata, mem_we, sp_out, sp_load, pc_out, pc_load,
               busy, done
    );
endinterface

// File: rtl/rst_call_push_sequencer_push_byte_writer.sv
// -----------------------------------------------------------------------------
// rst_call_push_sequencer_push_byte_writer
// Holds one memory write (address, data, write enable) until the memory
// accepts it, then returns to an all-zero idle output.
//   clock, reset   - system clock, synchronous active-high reset
//   load_i         - capture addr_i/data_i and raise mem_we_o next cycle
//   addr_i, data_i - write to be issued
//   mem_ready_i    - memory accepts the pending write this cycle
//   mem_addr_o, mem_wdata_o, mem_we_o - registered write port
//   accept_o       - pending write accepted this cycle
// -----------------------------------------------------------------------------
module rst_call_push_sequencer_push_byte_writer
    import rst_call_push_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    output logic              accept_o
);
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              we_q;

    assign accept_o    = we_q & mem_ready_i;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = data_q;
    assign mem_we_o    = we_q;

    // A new load wins over the accept clear so the second byte can be issued
    // in the same edge that retires the first one (no bubble between bytes).
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
        end else if (load_i) begin
            addr_q <= addr_i;
            data_q <= data_i;
            we_q   <= 1'b1;
        end else if (accept_o) begin
            addr_q <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
        end
    end
endmodule

// File: rtl/rst_call_push_sequencer.sv
// -----------------------------------------------------------------------------
// rst_call_push_sequencer
// Executes the stack push and PC redirect of RST n / CALL: pushes the return
// address (high byte at SP-1, low byte at SP-2), then loads SP-2 and the
// target into the register file and pulses done.
//   clock - system clock, all state on rising edge
//   reset - synchronous, active-high
//   bus   - slave side of rst_call_push_sequencer_if: start/is_call/vector/
//           call_target/pc_in/sp_in request, mem_* write port, sp_*/pc_*
//           register updates, busy and done status
// -----------------------------------------------------------------------------
module rst_call_push_sequencer
    import rst_call_push_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    rst_call_push_sequencer_if.slave    bus
);
    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] sp_q;
    logic [ADDR_W-1:0] tgt_q;
    logic [ADDR_W-1:0] sp_out_q;
    logic [ADDR_W-1:0] pc_out_q;
    logic              sp_load_q;
    logic              pc_load_q;
    logic              busy_q;
    logic              done_q;

    logic              wr_load;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_accept;
    logic [ADDR_W-1:0] wr_mem_addr;
    logic [DATA_W-1:0] wr_mem_wdata;
    logic              wr_mem_we;

    logic [DATA_W-1:0] first_byte_in;
    logic [DATA_W-1:0] second_byte_q;
    logic [ADDR_W-1:0] target_in;

    assign first_byte_in = PUSH_HIGH_FIRST ? bus.pc_in[ADDR_W-1 -: DATA_W]
                                           : bus.pc_in[DATA_W-1:0];
    assign second_byte_q = PUSH_HIGH_FIRST ? pc_q[DATA_W-1:0]
                                           : pc_q[ADDR_W-1 -: DATA_W];
    assign target_in     = bus.is_call ? bus.call_target
                                       : (ADDR_W'(bus.vector) << RST_VECTOR_SHIFT);

    // First byte is issued straight from the request inputs so the write is
    // already on the bus in the first WR_HI cycle.
    always_comb begin
        wr_load = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    wr_load = 1'b1;
                    wr_addr = bus.sp_in - ADDR_W'(PUSH_FIRST_OFFSET);
                    wr_data = first_byte_in;
                end
            end
            ST_WR_HI: begin
                if (wr_accept) begin
                    wr_load = 1'b1;
                    wr_addr = sp_q - ADDR_W'(PUSH_SECOND_OFFSET);
                    wr_data = second_byte_q;
                end
            end
            default: ;
        endcase
    end

    rst_call_push_sequencer_push_byte_writer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_writer (
        .clock       (clock),
        .reset       (reset),
        .load_i      (wr_load),
        .addr_i      (wr_addr),
        .data_i      (wr_data),
        .mem_ready_i (bus.mem_ready),
        .mem_addr_o  (wr_mem_addr),
        .mem_wdata_o (wr_mem_wdata),
        .mem_we_o    (wr_mem_we),
        .accept_o    (wr_accept)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            sp_q      <= '0;
            tgt_q     <= '0;
            sp_out_q  <= '0;
            pc_out_q  <= '0;
            sp_load_q <= 1'b0;
            pc_load_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            sp_load_q <= 1'b0;
            pc_load_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        pc_q    <= bus.pc_in;
                        sp_q    <= bus.sp_in;
                        tgt_q   <= target_in;
                        busy_q  <= 1'b1;
                        state_q <= ST_WR_HI;
                    end
                end
                ST_WR_HI: begin
                    if (wr_accept) state_q <= ST_WR_LO;
                end
                ST_WR_LO: begin
                    // Register updates are set up here so they are visible
                    // during the LOAD cycle itself.
                    if (wr_accept) begin
                        sp_out_q  <= sp_q - ADDR_W'(PUSH_SECOND_OFFSET);
                        pc_out_q  <= tgt_q;
                        sp_load_q <= 1'b1;
                        pc_load_q <= 1'b1;
                        state_q   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr  = wr_mem_addr;
    assign bus.mem_wdata = wr_mem_wdata;
    assign bus.mem_we    = wr_mem_we;
    assign bus.sp_out    = sp_out_q;
    assign bus.sp_load   = sp_load_q;
    assign bus.pc_out    = pc_out_q;
    assign bus.pc_load   = pc_load_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_rst_call_push_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rst_call_push_sequencer
// Scoreboard bench: the stimulus process computes every write, register load
// and done pulse (with its cycle) from the instruction semantics and queues
// them; the monitor compares them against what the DUT presents.
// -----------------------------------------------------------------------------
module tb_rst_call_push_sequencer;

    localparam int K_WR   = 0;
    localparam int K_LOAD = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int          kind;
        int unsigned cyc;
        logic [15:0] a;
        logic [15:0] b;
        bit          aborted;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    rst_call_push_sequencer_if #(.ADDR_W(16), .DATA_W(8)) bus();

    rst_call_push_sequencer #(.ADDR_W(16), .DATA_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int unsigned busy_lo  = 1;
    int unsigned busy_hi  = 0;
    bit          mon_en   = 1'b0;
    int          n_load_exp  = 0;
    int          n_load_seen = 0;

    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        exp_t e;
        if (mon_en) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                if (!q[0].aborted) note_fail($sformatf("missing_event kind=%0d due=%0d", q[0].kind, q[0].cyc));
                void'(q.pop_front());
            end
            chk("busy", 32'(bus.busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
            if (bus.mem_we === 1'b1) begin
                if (q.size() == 0 || q[0].kind != K_WR) begin
                    note_fail("unexpected_write");
                end else if (bus.mem_ready) begin
                    e = q.pop_front();
                    chk("wr_cycle", 32'(cyc), 32'(e.cyc));
                    chk("wr_addr", 32'(bus.mem_addr), 32'(e.a));
                    chk("wr_data", 32'(bus.mem_wdata), 32'(e.b));
                end else begin
                    chk("hold_addr", 32'(bus.mem_addr), 32'(q[0].a));
                    chk("hold_data", 32'(bus.mem_wdata), 32'(q[0].b));
                end
            end else begin
                chk("mem_we_low", 32'(bus.mem_we), 32'd0);
                chk("idle_addr", 32'(bus.mem_addr), 32'd0);
                chk("idle_data", 32'(bus.mem_wdata), 32'd0);
            end
            if (bus.sp_load || bus.pc_load) begin
                n_load_seen++;
                if (q.size() == 0 || q[0].kind != K_LOAD) begin
                    note_fail("unexpected_load");
                end else begin
                    e = q.pop_front();
                    chk("load_cycle", 32'(cyc), 32'(e.cyc));
                    chk("sp_load", 32'(bus.sp_load), 32'd1);
                    chk("pc_load", 32'(bus.pc_load), 32'd1);
                    chk("sp_out", 32'(bus.sp_out), 32'(e.a));
                    chk("pc_out", 32'(bus.pc_out), 32'(e.b));
                end
            end
            if (bus.done) begin
                if (q.size() == 0 || q[0].kind != K_DONE) begin
                    note_fail("unexpected_done");
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic randomize_fields();
        bus.is_call     = 1'($urandom_range(0, 1));
        bus.vector      = 3'($urandom_range(0, 7));
        bus.call_target = 16'($urandom);
        bus.pc_in       = 16'($urandom);
        bus.sp_in       = 16'($urandom);
    endtask

    task automatic push_exp(input int kind, input int unsigned c, input logic [15:0] a,
                            input logic [15:0] b, input bit aborted);
        exp_t e;
        e.kind = kind; e.cyc = c; e.a = a; e.b = b; e.aborted = aborted;
        q.push_back(e);
    endtask

    task automatic run_seq(input bit is_call, input logic [2:0] vec, input logic [15:0] tgt,
                           input logic [15:0] pc, input logic [15:0] sp,
                           input int unsigned whi, input int unsigned wlo,
                           input bit rand_extra, input bit forced_extra);
        int unsigned last = 4 + whi + wlo;
        int unsigned c0   = 0;
        logic [15:0] target;
        target = is_call ? tgt : 16'(vec) * 16'd8;
        for (int unsigned off = 0; off <= last; off++) begin
            @(posedge clock); #1;
            if (off == 0) begin
                c0 = cyc;
                push_exp(K_WR,   c0 + 1 + whi,       sp - 16'd1, {8'h00, pc[15:8]}, 1'b0);
                push_exp(K_WR,   c0 + 2 + whi + wlo, sp - 16'd2, {8'h00, pc[7:0]},  1'b0);
                push_exp(K_LOAD, c0 + 3 + whi + wlo, sp - 16'd2, target,            1'b0);
                push_exp(K_DONE, c0 + last,          16'd0,      16'd0,             1'b0);
                busy_lo = c0 + 1;
                busy_hi = c0 + last;
                n_load_exp++;
                bus.start       = 1'b1;
                bus.is_call     = is_call;
                bus.vector      = vec;
                bus.call_target = tgt;
                bus.pc_in       = pc;
                bus.sp_in       = sp;
            end else begin
                randomize_fields();
                bus.start = 1'b0;
                if (rand_extra && $urandom_range(0, 3) == 0) bus.start = 1'b1;
                if (forced_extra && (off == 2 + whi || off == last)) bus.start = 1'b1;
            end
            if (off >= 1 && off <= whi)                   bus.mem_ready = 1'b0;
            else if (off == 1 + whi)                      bus.mem_ready = 1'b1;
            else if (off >= 2 + whi && off < 2 + whi + wlo) bus.mem_ready = 1'b0;
            else if (off == 2 + whi + wlo)                bus.mem_ready = 1'b1;
            else                                          bus.mem_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clock); #1;
            bus.start     = 1'b0;
            bus.mem_ready = 1'($urandom_range(0, 1));
            randomize_fields();
        end
    endtask

    // Reset lands in WR_LO while the low byte is stalled.
    task automatic run_reset(input logic [15:0] pc, input logic [15:0] sp,
                             input int unsigned whi, input int unsigned wl);
        int unsigned r  = 2 + whi + wl;
        int unsigned c0 = 0;
        for (int unsigned off = 0; off <= r + 1; off++) begin
            @(posedge clock); #1;
            if (off == 0) begin
                c0 = cyc;
                push_exp(K_WR, c0 + 1 + whi, sp - 16'd1, {8'h00, pc[15:8]}, 1'b0);
                push_exp(K_WR, c0 + r,       sp - 16'd2, {8'h00, pc[7:0]},  1'b1);
                busy_lo = c0 + 1;
                busy_hi = c0 + r;
                bus.start       = 1'b1;
                bus.is_call     = 1'b1;
                bus.call_target = 16'($urandom);
                bus.pc_in       = pc;
                bus.sp_in       = sp;
            end else begin
                bus.start = 1'b0;
                randomize_fields();
            end
            bus.mem_ready = (off == 1 + whi) ? 1'b1 : ((off == 0) ? 1'b1 : 1'b0);
            reset = (off == r);
            if (off == r + 1) begin
                chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
                chk("rst_busy", 32'(bus.busy), 32'd0);
                chk("rst_sp_load", 32'(bus.sp_load), 32'd0);
                chk("rst_pc_load", 32'(bus.pc_load), 32'd0);
            end
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.mem_ready   = 1'b0;
        bus.is_call     = 1'b0;
        bus.vector      = 3'd0;
        bus.call_target = 16'd0;
        bus.pc_in       = 16'd0;
        bus.sp_in       = 16'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_mem_we", 32'(bus.mem_we), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_sp_load", 32'(bus.sp_load), 32'd0);
        chk("reset_pc_load", 32'(bus.pc_load), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("reset_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("reset_sp_out", 32'(bus.sp_out), 32'd0);
        chk("reset_pc_out", 32'(bus.pc_out), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // RST 0x28, no wait states
        run_seq(1'b0, 3'd5, 16'h0000, 16'h1234, 16'h8000, 0, 0, 1'b0, 1'b0);
        // CALL with two wait states per byte
        run_seq(1'b1, 3'd0, 16'hBEEF, 16'h0103, 16'hF000, 2, 2, 1'b0, 1'b0);
        idle(2);
        // SP wrap
        run_seq(1'b0, 3'd3, 16'h0000, 16'hA55A, 16'h0001, 0, 0, 1'b0, 1'b0);
        // starts in WR_LO and in the DONE cycle are ignored
        run_seq(1'b1, 3'd0, 16'h4321, 16'h2468, 16'h1000, 1, 1, 1'b0, 1'b1);
        idle(1);
        // reset mid-operation, then a fresh sequence
        run_reset(16'h5678, 16'h3000, 1, 1);
        run_seq(1'b1, 3'd2, 16'hCAFE, 16'h9ABC, 16'h2000, 0, 1, 1'b0, 1'b0);
        // lowest and highest RST vectors
        run_seq(1'b0, 3'd0, 16'($urandom), 16'($urandom), 16'($urandom), 0, 0, 1'b0, 1'b0);
        run_seq(1'b0, 3'd7, 16'($urandom), 16'($urandom), 16'($urandom), 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_seq(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                    16'($urandom), 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                    1'b1, 1'b0);
            idle($urandom_range(0, 2));
        end

        idle(8);
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("load_count", 32'(n_load_seen), 32'(n_load_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
